// File: rtl/spi_frame_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : spi_frame_fsm
//  Purpose  : Frame sequencer for the SPI memory slave. Counts address bits,
//             decodes the R/W bit and issues one-clk strobes for address
//             latch, data-memory write, MISO shift-register load and burst
//             address increment. CS release aborts the frame cleanly.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_frame_fsm #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter bit BURST_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk_rise,
  input  logic sclk_fall,
  input  logic cs,
  input  logic lsbsrop,
  output logic addr_we,
  output logic dm_we,
  output logic sr_we,
  output logic miso_bufe,
  output logic addr_inc,
  output logic busy,
  output logic frame_err
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W + 1);

  localparam logic [CNT_W-1:0] C_ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] C_DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ADDR    = 4'd1,
    S_RW_WAIT = 4'd2,
    S_RW_EVAL = 4'd3,
    S_WR      = 4'd4,
    S_WR_INC  = 4'd5,
    S_RD_LOAD = 4'd6,
    S_RD      = 4'd7,
    S_HOLD    = 4'd8
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Set once the first data unit of the frame has completed; an abort after
  // that point is a legitimate end of a burst, not a frame error.
  logic             done_q, done_d;
  logic             addr_we_q, addr_we_d;
  logic             dm_we_q, dm_we_d;
  logic             sr_we_q, sr_we_d;
  logic             miso_bufe_q, miso_bufe_d;
  logic             addr_inc_q, addr_inc_d;
  logic             busy_q, busy_d;
  logic             frame_err_q, frame_err_d;

  // Next-state and next-output decode; a CS release outranks any SCLK edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    addr_we_d   = 1'b0;
    dm_we_d     = 1'b0;
    sr_we_d     = 1'b0;
    miso_bufe_d = 1'b0;
    addr_inc_d  = 1'b0;
    frame_err_d = 1'b0;

    if (cs && (state_q != S_IDLE) && (state_q != S_HOLD)) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      done_d      = 1'b0;
      frame_err_d = ~done_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d  = '0;
          done_d = 1'b0;
          if (!cs) state_d = S_ADDR;
        end
        S_ADDR: begin
          if (sclk_rise) begin
            if (cnt_q == C_ADDR_LAST) begin
              addr_we_d = 1'b1;
              cnt_d     = '0;
              state_d   = S_RW_WAIT;
            end else begin
              cnt_d = cnt_q + C_ONE;
            end
          end
        end
        S_RW_WAIT: begin
          if (sclk_rise) state_d = S_RW_EVAL;
        end
        S_RW_EVAL: begin
          cnt_d   = '0;
          state_d = lsbsrop ? S_RD_LOAD : S_WR;
        end
        S_WR: begin
          if (sclk_rise) begin
            if (cnt_q == C_DATA_LAST) begin
              dm_we_d = 1'b1;
              done_d  = 1'b1;
              cnt_d   = '0;
              state_d = BURST_EN ? S_WR_INC : S_HOLD;
            end else begin
              cnt_d = cnt_q + C_ONE;
            end
          end
        end
        S_WR_INC: begin
          // addr_inc trails dm_we by one clk so the write uses the old address
          addr_inc_d = 1'b1;
          cnt_d      = sclk_rise ? C_ONE : '0;
          state_d    = S_WR;
        end
        S_RD_LOAD: begin
          // keeps the driver enabled between burst units
          miso_bufe_d = miso_bufe_q;
          if (sclk_fall) begin
            sr_we_d     = 1'b1;
            miso_bufe_d = 1'b1;
            cnt_d       = '0;
            state_d     = S_RD;
          end
        end
        S_RD: begin
          miso_bufe_d = 1'b1;
          if (sclk_rise) begin
            if (cnt_q == C_DATA_LAST) begin
              done_d = 1'b1;
              cnt_d  = '0;
              if (BURST_EN) begin
                addr_inc_d = 1'b1;
                state_d    = S_RD_LOAD;
              end else begin
                miso_bufe_d = 1'b0;
                state_d     = S_HOLD;
              end
            end else begin
              cnt_d = cnt_q + C_ONE;
            end
          end
        end
        S_HOLD: begin
          if (cs) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State, counter and registered outputs; reset drops every output at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      addr_we_q   <= 1'b0;
      dm_we_q     <= 1'b0;
      sr_we_q     <= 1'b0;
      miso_bufe_q <= 1'b0;
      addr_inc_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      addr_we_q   <= addr_we_d;
      dm_we_q     <= dm_we_d;
      sr_we_q     <= sr_we_d;
      miso_bufe_q <= miso_bufe_d;
      addr_inc_q  <= addr_inc_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign addr_we   = addr_we_q;
  assign dm_we     = dm_we_q;
  assign sr_we     = sr_we_q;
  assign miso_bufe = miso_bufe_q;
  assign addr_inc  = addr_inc_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_fsm.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_spi_frame_fsm
//  Purpose  : Scoreboard bench for spi_frame_fsm. Two instances: dut 0 with
//             default parameters (burst on), dut 1 with BURST_EN=0. Expected
//             strobe pulses and busy/miso_bufe transitions are queued by the
//             stimulus and popped by an independent monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_frame_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk_rise = 1'b0;
  logic sclk_fall = 1'b0;
  logic lsbsrop = 1'b0;
  logic cs_a = 1'b1;
  logic cs_b = 1'b1;

  logic awe_a, dmwe_a, srwe_a, miso_a, ainc_a, busy_a, ferr_a;
  logic awe_b, dmwe_b, srwe_b, miso_b, ainc_b, busy_b, ferr_b;

  spi_frame_fsm u_dut_a (
    .clk(clk), .rst_n(rst_n), .sclk_rise(sclk_rise), .sclk_fall(sclk_fall),
    .cs(cs_a), .lsbsrop(lsbsrop), .addr_we(awe_a), .dm_we(dmwe_a),
    .sr_we(srwe_a), .miso_bufe(miso_a), .addr_inc(ainc_a), .busy(busy_a),
    .frame_err(ferr_a)
  );

  spi_frame_fsm #(.ADDR_W(7), .DATA_W(8), .BURST_EN(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .sclk_rise(sclk_rise), .sclk_fall(sclk_fall),
    .cs(cs_b), .lsbsrop(lsbsrop), .addr_we(awe_b), .dm_we(dmwe_b),
    .sr_we(srwe_b), .miso_bufe(miso_b), .addr_inc(ainc_b), .busy(busy_b),
    .frame_err(ferr_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Event kinds: strobe pulses, then level transitions
  localparam int K_AWE = 0, K_DMWE = 1, K_SRWE = 2, K_AINC = 3, K_FERR = 4;
  localparam int K_MUP = 5, K_MDN = 6, K_BUP = 7, K_BDN = 8;
  localparam logic [8:0] M_NONE = 9'd0;
  localparam logic [8:0] M_AWE  = 9'd1 << K_AWE;
  localparam logic [8:0] M_DMWE = 9'd1 << K_DMWE;
  localparam logic [8:0] M_SRWE = 9'd1 << K_SRWE;
  localparam logic [8:0] M_AINC = 9'd1 << K_AINC;
  localparam logic [8:0] M_MUP  = 9'd1 << K_MUP;
  localparam logic [8:0] M_MDN  = 9'd1 << K_MDN;

  typedef struct {
    int dut;
    int kind;
    int cyc;
  } ev_t;
  ev_t exp_q[$];

  logic [6:0] st_a, st_b;
  assign st_a = {busy_a, miso_a, ferr_a, ainc_a, srwe_a, dmwe_a, awe_a};
  assign st_b = {busy_b, miso_b, ferr_b, ainc_b, srwe_b, dmwe_b, awe_b};

  function automatic string kname(input int k);
    case (k)
      K_AWE:   return "addr_we";
      K_DMWE:  return "dm_we";
      K_SRWE:  return "sr_we";
      K_AINC:  return "addr_inc";
      K_FERR:  return "frame_err";
      K_MUP:   return "miso_bufe_rise";
      K_MDN:   return "miso_bufe_fall";
      K_BUP:   return "busy_rise";
      default: return "busy_fall";
    endcase
  endfunction

  // Monitor: every output pulse or level change pops one expected event
  logic [6:0] prev_a = '0;
  logic [6:0] prev_b = '0;
  always @(negedge clk) begin : mon
    logic [6:0] st;
    logic [6:0] pv;
    logic [8:0] ev;
    ev_t        e;
    for (int d = 0; d < 2; d++) begin
      st = (d == 0) ? st_a : st_b;
      pv = (d == 0) ? prev_a : prev_b;
      ev[4:0] = st[4:0];
      ev[5]   = st[5] & ~pv[5];
      ev[6]   = ~st[5] & pv[5];
      ev[7]   = st[6] & ~pv[6];
      ev[8]   = ~st[6] & pv[6];
      if (d == 0) prev_a = st;
      else        prev_b = st;
      for (int k = 0; k < 9; k++) begin
        if (ev[k]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: dut%0d %s at cyc %0d, required none",
                     d, kname(k), cyc);
          end else begin
            e = exp_q.pop_front();
            if (e.dut != d || e.kind != k || e.cyc != cyc) begin
              errors++;
              $display("FAIL event: got dut%0d %s at cyc %0d, required dut%0d %s at cyc %0d",
                       d, kname(k), cyc, e.dut, kname(e.kind), e.cyc);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input int k, input int c);
    ev_t e;
    e.dut  = d;
    e.kind = k;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic push_mask(input int d, input logic [8:0] m, input int c);
    for (int k = 0; k < 9; k++)
      if (m[k]) push(d, k, c);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Drive cs for one dut; busy follows one clk later, frame_err with it on abort
  task automatic cs_set(input int d, input logic v, input bit ferr);
    if (d == 0) cs_a = v;
    else        cs_b = v;
    if (v && ferr) push(d, K_FERR, cyc + 1);
    push(d, v ? K_BDN : K_BUP, cyc + 1);
  endtask

  // One SCLK bit: fall pulse, two idle clks, rise pulse, two idle clks
  task automatic sbit(input int d, input logic [8:0] fmask, input logic [8:0] rmask1,
                      input logic [8:0] rmask2, input bit raise, input bit ferr);
    sclk_fall = 1'b1;
    push_mask(d, fmask, cyc + 1);
    tick();
    sclk_fall = 1'b0;
    tick();
    tick();
    sclk_rise = 1'b1;
    push_mask(d, rmask1, cyc + 1);
    push_mask(d, rmask2, cyc + 2);
    tick();
    sclk_rise = 1'b0;
    if (raise) cs_set(d, 1'b1, ferr);
    tick();
    tick();
  endtask

  // CS low, 7 address bits, R/W bit
  task automatic addr_phase(input int d, input logic rw);
    cs_set(d, 1'b0, 1'b0);
    tick();
    tick();
    for (int i = 1; i <= 7; i++)
      sbit(d, M_NONE, (i == 7) ? M_AWE : M_NONE, M_NONE, 1'b0, 1'b0);
    lsbsrop = rw;
    sbit(d, M_NONE, M_NONE, M_NONE, 1'b0, 1'b0);
  endtask

  // Single write on dut 0, cs released in the dm_we clk so no addr_inc follows
  task automatic write_single_a();
    addr_phase(0, 1'b0);
    for (int i = 1; i <= 8; i++)
      sbit(0, M_NONE, (i == 8) ? M_DMWE : M_NONE, M_NONE, i == 8, 1'b0);
    tick();
    chk("t1_busy_idle", {31'd0, busy_a}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached before end of stimulus");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("reset_outputs_a", {25'd0, st_a}, 32'd0);
    chk("reset_outputs_b", {25'd0, st_b}, 32'd0);
    tick();

    // 1: default write frame
    write_single_a();
    tick();

    // 2: non-burst read frame on dut 1
    addr_phase(1, 1'b1);
    for (int i = 1; i <= 8; i++)
      sbit(1, (i == 1) ? (M_SRWE | M_MUP) : M_NONE, (i == 8) ? M_MDN : M_NONE,
           M_NONE, 1'b0, 1'b0);
    chk("t2_busy_hold", {31'd0, busy_b}, 32'd1);
    cs_set(1, 1'b1, 1'b0);
    tick();
    tick();

    // 2b: burst read of two units on dut 0, abort after second unit
    addr_phase(0, 1'b1);
    for (int i = 1; i <= 16; i++)
      sbit(0, (i == 1) ? (M_SRWE | M_MUP) : ((i == 9) ? M_SRWE : M_NONE),
           (i % 8 == 0) ? M_AINC : M_NONE, M_NONE, 1'b0, 1'b0);
    push(0, K_MDN, cyc + 1);
    cs_set(0, 1'b1, 1'b0);
    tick();
    tick();

    // 3: burst write of three units on dut 0
    addr_phase(0, 1'b0);
    for (int i = 1; i <= 24; i++)
      sbit(0, M_NONE, (i % 8 == 0) ? M_DMWE : M_NONE,
           (i % 8 == 0) ? M_AINC : M_NONE, 1'b0, 1'b0);
    cs_set(0, 1'b1, 1'b0);
    tick();
    tick();

    // 4: non-burst write on dut 1, extra edges ignored in HOLD
    addr_phase(1, 1'b0);
    for (int i = 1; i <= 16; i++)
      sbit(1, M_NONE, (i == 8) ? M_DMWE : M_NONE, M_NONE, 1'b0, 1'b0);
    chk("t4_busy_hold", {31'd0, busy_b}, 32'd1);
    cs_set(1, 1'b1, 1'b0);
    tick();
    chk("t4_busy_idle", {31'd0, busy_b}, 32'd0);
    tick();

    // 5: write aborted after data rise 4
    addr_phase(0, 1'b0);
    for (int i = 1; i <= 4; i++)
      sbit(0, M_NONE, M_NONE, M_NONE, i == 4, 1'b1);
    chk("t5_busy_idle", {31'd0, busy_a}, 32'd0);
    tick();

    // 6: asynchronous reset during address phase, then a clean write
    cs_set(0, 1'b0, 1'b0);
    tick();
    tick();
    for (int i = 1; i <= 3; i++)
      sbit(0, M_NONE, M_NONE, M_NONE, 1'b0, 1'b0);
    chk("t6_busy_before_reset", {31'd0, busy_a}, 32'd1);
    #2;
    rst_n = 1'b0;
    push(0, K_BDN, cyc);
    #1;
    chk("t6_async_reset_outputs", {25'd0, st_a}, 32'd0);
    cs_a = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    write_single_a();
    tick();
    tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: %0d expected events never seen, required 0",
               exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_frame_fsm.md
Name: spi_frame_fsm

Overview:
Parametrised control FSM for the SPI memory slave. It sequences address capture, the read/write decision, data-memory write strobes and MISO shift-register loads. It runs on the system clock and consumes the single-cycle SCLK edge pulses and the synchronised CS from the input conditioners. Address and data widths are configurable, with optional burst (auto-increment) transfers and clean abort on CS release.

Parameters:
ADDR_W, 7, address bits per frame (>=1)
DATA_W, 8, data bits per transfer unit (>=2)
BURST_EN, 1, 1 = continue with next data unit at address+1 while CS stays low; 0 = single transfer per frame

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
sclk_rise  input  1  one-clk pulse per SCLK rising edge (conditioned)
sclk_fall  input  1  one-clk pulse per SCLK falling edge (conditioned)
cs  input  1  synchronised chip select, active low
lsbsrop  input  1  shift-register LSB (valid the clk after a sclk_rise)
addr_we  output  1  one-clk pulse: latch full address from shift register
dm_we  output  1  one-clk pulse: write shift-register data to data memory
sr_we  output  1  one-clk pulse: parallel-load memory read data into shift register
miso_bufe  output  1  MISO tristate enable, high during read data phase
addr_inc  output  1  one-clk pulse: increment address latch (burst only)
busy  output  1  high whenever state != IDLE
frame_err  output  1  one-clk pulse: CS released before first data unit completed

Behaviour:
- Reset is asynchronous (rst_n low): state IDLE, bit counter 0, all outputs 0. Reset mid-frame discards the frame with no strobes.
- Bit counter width is $clog2(max(ADDR_W,DATA_W)+1). The counter clears on every state entry that starts a count.
- IDLE: when cs==0, go to ADDR with cnt=0.
- ADDR: cnt++ on each sclk_rise. On the ADDR_W-th rise go to RW_WAIT. addr_we pulses in the clk after that rise.
- RW_WAIT: on the next sclk_rise go to RW_EVAL.
- RW_EVAL: lasts one clk and samples lsbsrop.
  - lsbsrop 0: go to WR with cnt=0.
  - lsbsrop 1: go to RD_LOAD.
- WR: cnt++ per sclk_rise. On the DATA_W-th rise, dm_we pulses in the next clk.
  - BURST_EN=1 and cs still 0: addr_inc pulses the clk after dm_we, then WR restarts with cnt=0.
  - Otherwise go to HOLD.
- RD_LOAD: on the next sclk_fall, sr_we pulses for that clk, miso_bufe goes 1, and the FSM goes to RD with cnt=0.
- RD: miso_bufe held 1. cnt++ per sclk_rise. On the DATA_W-th rise:
  - BURST_EN=1 and cs 0: addr_inc pulses for one clk, then back to RD_LOAD (miso_bufe stays 1).
  - Otherwise miso_bufe goes 0 and the FSM goes to HOLD.
- HOLD: all strobes 0, miso_bufe 0. Extra SCLK edges are ignored. When cs==1, go to IDLE.
- CS abort: cs==1 in any state other than IDLE or HOLD forces IDLE on the next clk.
  - All outputs go 0, and any dm_we, sr_we or addr_inc not yet issued is suppressed.
  - cs has priority over a simultaneous sclk edge.
  - frame_err pulses once if the abort occurs before the first dm_we or first completed read unit. Aborts during later burst units do not raise frame_err.
- Strobes are never asserted together except sr_we with miso_bufe. dm_we and addr_inc are never in the same clk.
- SCLK pulses while in IDLE are ignored.

Test Plan:
1. Defaults; 7 addr bits, RW=0, 8 data bits, then cs high -> addr_we one pulse the clk after rise 7; dm_we exactly one pulse the clk after rise 16; addr_inc, sr_we, miso_bufe stay 0; busy falls the clk after cs high.
2. Read frame, RW=1 -> sr_we one pulse on the first sclk_fall after rise 8. miso_bufe is 1 from that clk until the clk after rise 16, then 0. dm_we never asserts.
3. BURST_EN=1, write of 3 data units with cs low throughout -> 3 dm_we pulses, each followed next clk by an addr_inc pulse (3 total). frame_err stays 0.
4. BURST_EN=0, 16 data rises after RW=0 -> one dm_we. The FSM stays in HOLD (busy=1) until cs high, then IDLE.
5. Write with cs released after data rise 4 -> no dm_we, frame_err one pulse, IDLE and busy=0 next clk.
6. rst_n low during ADDR (after 3 rises) -> all outputs 0 immediately, no clk needed. A subsequent full write frame behaves as in scenario 1.
